lc3_ctrl: RTL and testbench

Multi-cycle control unit for the LC-3 core. Fetches instructions over a simple request/ready memory handshake, decodes them, and drives the datapath. Its outputs include the 2-bit ALU function select, operand and writeback selects, register-file addresses, and PC load controls. It produces the `alu_k`/operand controls that the ALU consumes and samples the condition codes the datapath derives from the ALU result. Supported subset: ADD, AND, NOT, BR, JMP, LD, ST, LEA.

---
 rtl/lc3_pkg.sv | 71 +++++++
 rtl/lc3_ctrl_if.sv | 25 ++
 rtl/lc3_ctrl_decode.sv | 55 +++++
 rtl/lc3_ctrl.sv | 155 +++++++++++++++
 tb/tb_lc3_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: opcodes, ALU/PC/writeback encodings,
// FSM states and the decoded-instruction record.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LEA = 4'hE;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_k_e;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_IMM = 2'b01,
    PC_REG = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU   = 2'b00,
    WB_MEM   = 2'b01,
    WB_PCIMM = 2'b10
  } wb_sel_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  // Instruction class as seen by the FSM; everything unsupported is CLS_NOP.
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_BR,
    CLS_JMP,
    CLS_LEA,
    CLS_LD,
    CLS_ST
  } cls_e;

  typedef struct packed {
    cls_e        cls;
    alu_k_e      alu_k;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  dr;
    logic        op_b_sel;
    logic [15:0] imm16;
    logic        br_taken;
  } dec_t;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

endpackage

// File: rtl/lc3_ctrl_if.sv
// Instruction/data memory request-ready handshake between the LC-3 control
// unit (master) and the memory system (slave).
interface lc3_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/lc3_ctrl_decode.sv
// Combinational IR decode: register fields, sign-extended immediate, ALU
// function, instruction class and branch condition evaluation.
module lc3_ctrl_decode
  import lc3_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  output dec_t        dec
);

  // NOTE: every field gets a default before the case so no path leaves a
  // field unassigned, which would otherwise infer a latch.
  always_comb begin
    dec          = '0;
    dec.cls      = CLS_NOP;
    dec.alu_k    = ALU_PASS;
    dec.dr       = ir[11:9];
    dec.sr1      = ir[8:6];
    dec.sr2      = ir[2:0];
    dec.imm16    = sext9(ir[8:0]);
    dec.br_taken = |(ir[11:9] & nzp);

    case (ir[15:12])
      OP_ADD: begin
        dec.cls      = CLS_ALU;
        dec.alu_k    = ALU_ADD;
        dec.op_b_sel = ir[5];
        dec.imm16    = sext5(ir[4:0]);
      end
      OP_AND: begin
        dec.cls      = CLS_ALU;
        dec.alu_k    = ALU_AND;
        dec.op_b_sel = ir[5];
        dec.imm16    = sext5(ir[4:0]);
      end
      OP_NOT: begin
        dec.cls      = CLS_ALU;
        dec.alu_k    = ALU_NOT;
        dec.op_b_sel = 1'b0;
        dec.imm16    = sext5(ir[4:0]);
      end
      OP_BR:  dec.cls = CLS_BR;
      OP_JMP: dec.cls = CLS_JMP;
      OP_LEA: dec.cls = CLS_LEA;
      OP_LD:  dec.cls = CLS_LD;
      OP_ST: begin
        // ST reads its source register from the DR field position.
        dec.cls = CLS_ST;
        dec.sr1 = ir[11:9];
      end
      default: dec.cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/lc3_ctrl.sv
// LC-3 multi-cycle control unit: FETCH/DECODE/EXEC/MEM FSM plus IR.
// Build option LC3_ILLEGAL_HALT_EN: unsupported opcodes halt and raise illegal.
module lc3_ctrl
  import lc3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  lc3_ctrl_if.master        mem,
  input  logic [2:0]        nzp,
  output logic [1:0]        alu_k,
  output logic [2:0]        sr1,
  output logic [2:0]        sr2,
  output logic [2:0]        dr,
  output logic              op_b_sel,
  output logic [15:0]       imm16,
  output logic [1:0]        wb_sel,
  output logic              reg_we,
  output logic              ld_cc,
  output logic              pc_ld,
  output logic [1:0]        pc_sel,
  output logic              illegal
);

  state_e      state, state_nxt;
  logic [15:0] ir;
  logic        ir_ld;
  dec_t        dec;

  logic        req_c, we_c, asel_c, obs_c;
  logic        reg_we_c, ld_cc_c, pc_ld_c;
  alu_k_e      alu_c;
  wb_sel_e     wb_c;
  pc_sel_e     pcs_c;

  lc3_ctrl_decode u_decode (
    .ir  (ir),
    .nzp (nzp),
    .dec (dec)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (ir_ld) ir <= mem.mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_ld     = 1'b0;
    req_c     = 1'b0;
    we_c      = 1'b0;
    asel_c    = 1'b0;
    obs_c     = 1'b0;
    alu_c     = ALU_PASS;
    wb_c      = WB_ALU;
    pcs_c     = PC_INC;
    reg_we_c  = 1'b0;
    ld_cc_c   = 1'b0;
    pc_ld_c   = 1'b0;

    case (state)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_ld     = 1'b1;
          pc_ld_c   = 1'b1;
          pcs_c     = PC_INC;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: state_nxt = S_EXEC;

      S_EXEC: begin
        state_nxt = S_FETCH;
        alu_c     = dec.alu_k;
        case (dec.cls)
          CLS_ALU: begin
            obs_c    = dec.op_b_sel;
            wb_c     = WB_ALU;
            reg_we_c = 1'b1;
            ld_cc_c  = 1'b1;
          end
          CLS_BR: begin
            pcs_c   = PC_IMM;
            pc_ld_c = dec.br_taken;
          end
          CLS_JMP: begin
            pcs_c   = PC_REG;
            pc_ld_c = 1'b1;
          end
          CLS_LEA: begin
            wb_c     = WB_PCIMM;
            reg_we_c = 1'b1;
          end
          CLS_LD, CLS_ST: state_nxt = S_MEM;
          default: begin
`ifdef LC3_ILLEGAL_HALT_EN
            state_nxt = S_HALT;
`else
            state_nxt = S_FETCH;
`endif
          end
        endcase
      end

      S_MEM: begin
        // Request fields are a function of IR only, so they hold until ready.
        req_c  = 1'b1;
        asel_c = 1'b1;
        we_c   = (dec.cls == CLS_ST);
        if (dec.cls == CLS_LD) wb_c = WB_MEM;
        if (mem.mem_ready) begin
          reg_we_c  = (dec.cls == CLS_LD);
          ld_cc_c   = (dec.cls == CLS_LD);
          state_nxt = S_FETCH;
        end
      end

      S_HALT: state_nxt = S_HALT;

      default: state_nxt = S_FETCH;
    endcase
  end

  // NOTE: the FSM resets into FETCH, which would otherwise drive mem_req while
  // reset is held; gating with rst_n also abandons an in-flight request at once.
  assign mem.mem_req  = rst_n & req_c;
  assign mem.mem_we   = rst_n & we_c;
  assign mem.addr_sel = rst_n & asel_c;
  assign alu_k        = rst_n ? alu_c : ALU_PASS;
  assign sr1          = rst_n ? dec.sr1 : 3'd0;
  assign sr2          = rst_n ? dec.sr2 : 3'd0;
  assign dr           = rst_n ? dec.dr : 3'd0;
  assign op_b_sel     = rst_n & obs_c;
  assign imm16        = rst_n ? dec.imm16 : 16'h0000;
  assign wb_sel       = rst_n ? wb_c : WB_ALU;
  assign reg_we       = rst_n & reg_we_c;
  assign ld_cc        = rst_n & ld_cc_c;
  assign pc_ld        = rst_n & pc_ld_c;
  assign pc_sel       = rst_n ? pcs_c : PC_INC;

`ifdef LC3_ILLEGAL_HALT_EN
  assign illegal = rst_n && (state == S_HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_ctrl.sv
// Scoreboard bench for lc3_ctrl: directed instructions push expected strobe
// events; a negedge monitor pops and compares whenever the DUT strobes.
module tb_lc3_ctrl;

  typedef struct packed {
    logic        mem_req, mem_we, addr_sel, reg_we, ld_cc, pc_ld;
    logic [1:0]  wb_sel, pc_sel, alu_k;
    logic [2:0]  sr1, sr2, dr;
    logic        op_b_sel;
    logic [15:0] imm16;
  } sig_t;

  typedef struct {
    string      name;
    int         cyc;
    sig_t       s;
    logic [5:0] mask;
  } exp_t;

  localparam logic [5:0] M_ALU = 6'b100000;
  localparam logic [5:0] M_SR1 = 6'b010000;
  localparam logic [5:0] M_SR2 = 6'b001000;
  localparam logic [5:0] M_DR  = 6'b000100;
  localparam logic [5:0] M_OPB = 6'b000010;
  localparam logic [5:0] M_IMM = 6'b000001;
  localparam sig_t       NONE  = '0;
  localparam logic [38:0] RST_OUTS = {3'b000, 2'b11, 34'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  nzp = 3'b000;
  logic [1:0]  alu_k, wb_sel, pc_sel;
  logic [2:0]  sr1, sr2, dr;
  logic        op_b_sel, reg_we, ld_cc, pc_ld, illegal;
  logic [15:0] imm16;

  lc3_ctrl_if mem_bus ();

  lc3_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem      (mem_bus),
    .nzp      (nzp),
    .alu_k    (alu_k),
    .sr1      (sr1),
    .sr2      (sr2),
    .dr       (dr),
    .op_b_sel (op_b_sel),
    .imm16    (imm16),
    .wb_sel   (wb_sel),
    .reg_we   (reg_we),
    .ld_cc    (ld_cc),
    .pc_ld    (pc_ld),
    .pc_sel   (pc_sel),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  sig_t        act_sig;
  logic [38:0] out_vec;
  assign act_sig = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.addr_sel, reg_we, ld_cc, pc_ld,
                    wb_sel, pc_sel, alu_k, sr1, sr2, dr, op_b_sel, imm16};
  assign out_vec = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.addr_sel, alu_k, sr1, sr2, dr,
                    op_b_sel, imm16, wb_sel, reg_we, ld_cc, pc_ld, pc_sel, illegal};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic sig_t mk(input logic req, we, asel, rwe, ldcc, pcld,
                              input logic [1:0] wb, pcs, alu,
                              input logic [2:0] s1, s2, d,
                              input logic opb, input logic [15:0] imm);
    return {req, we, asel, rwe, ldcc, pcld, wb, pcs, alu, s1, s2, d, opb, imm};
  endfunction

  // Strobes and memory controls are always compared; selects only alongside
  // their strobe; decode fields only where the event names them.
  function automatic sig_t sig_mask(input sig_t s, input logic [5:0] m);
    sig_t r;
    r          = '0;
    r.mem_req  = 1'b1;
    r.mem_we   = 1'b1;
    r.addr_sel = 1'b1;
    r.reg_we   = 1'b1;
    r.ld_cc    = 1'b1;
    r.pc_ld    = 1'b1;
    r.wb_sel   = s.reg_we ? 2'b11 : 2'b00;
    r.pc_sel   = s.pc_ld ? 2'b11 : 2'b00;
    r.alu_k    = {2{m[5]}};
    r.sr1      = {3{m[4]}};
    r.sr2      = {3{m[3]}};
    r.dr       = {3{m[2]}};
    r.op_b_sel = m[1];
    r.imm16    = {16{m[0]}};
    return r;
  endfunction

  task automatic push(input string name, input int c, input sig_t s, input logic [5:0] m);
    exp_t e;
    e.name = name;
    e.cyc  = c;
    e.s    = s;
    e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshake-hold rule every cycle, scoreboard pop on any strobe.
  logic [2:0] prev_ctl;
  logic       prev_ok = 1'b0, prev_req = 1'b0, prev_ready = 1'b0;
  exp_t       mon_e;
  sig_t       mon_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok && prev_req && !prev_ready)
        check("req_hold", {61'd0, mem_bus.mem_req, mem_bus.mem_we, mem_bus.addr_sel},
              {61'd0, prev_ctl});
      prev_ok    = 1'b1;
      prev_req   = mem_bus.mem_req;
      prev_ready = mem_bus.mem_ready;
      prev_ctl   = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.addr_sel};
      if ((mem_bus.mem_req && mem_bus.mem_ready) || reg_we || pc_ld || ld_cc) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_strobe actual=%0h expected=none (cycle %0d)", act_sig, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_m = sig_mask(mon_e.s, mon_e.mask);
          check({mon_e.name, "_sig"}, act_sig & mon_m, mon_e.s & mon_m);
          check({mon_e.name, "_cyc"}, cyc, mon_e.cyc);
        end
      end
    end
  end

  // Drives one instruction from its FETCH cycle; mw < 0 means no MEM phase.
  task automatic run_instr(input string name, input logic [15:0] ir, input logic [2:0] nzp_v,
                           input int fw, input bit has_exec, input sig_t ex_s,
                           input logic [5:0] ex_m, input int mw, input sig_t mem_s,
                           input logic [5:0] mem_m);
    int t0;
    t0  = cyc;
    nzp = nzp_v;
    for (int i = 0; i < fw; i++) begin
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 16'hFFFF;
      step();
    end
    push({name, "_fetch"}, t0 + fw, mk(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0), M_ALU);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = ir;
    step();
    // DECODE and EXEC: ready stays high but must be ignored with no request.
    mem_bus.mem_rdata = 16'hF0F0;
    if (has_exec) push({name, "_exec"}, t0 + fw + 2, ex_s, ex_m);
    step();
    step();
    mem_bus.mem_ready = 1'b0;
    if (mw >= 0) begin
      for (int i = 0; i < mw; i++) step();
      push({name, "_mem"}, t0 + fw + 3 + mw, mem_s, mem_m);
      mem_bus.mem_ready = 1'b1;
      mem_bus.mem_rdata = 16'h1234;
      step();
      mem_bus.mem_ready = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'h1262;
    nzp = 3'b111;
    #3;
    check("reset_outputs", {25'd0, out_vec}, {25'd0, RST_OUTS});
    step();
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("first_fetch_req", {61'd0, mem_bus.mem_req, mem_bus.addr_sel, mem_bus.mem_we},
          {61'd0, 3'b100});

    run_instr("add", 16'h1262, 3'b001, 0, 1,
              mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'd1, 3'd0, 3'd1, 1'b1, 16'h0002),
              M_ALU | M_SR1 | M_DR | M_OPB | M_IMM, -1, NONE, '0);
    run_instr("and", 16'h54C4, 3'b010, 1, 1,
              mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b01, 3'd3, 3'd4, 3'd2, 1'b0, 16'h0000),
              M_ALU | M_SR1 | M_SR2 | M_DR | M_OPB, -1, NONE, '0);
    run_instr("not", 16'h9BBF, 3'b100, 0, 1,
              mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b10, 3'd6, 3'd0, 3'd5, 1'b0, 16'h0000),
              M_ALU | M_SR1 | M_DR | M_OPB, -1, NONE, '0);
    run_instr("brz_taken", 16'h05FD, 3'b010, 0, 1,
              mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b11, 3'd0, 3'd0, 3'd0, 1'b0, 16'hFFFD),
              M_IMM, -1, NONE, '0);
    run_instr("brz_not_taken", 16'h05FD, 3'b100, 0, 0, NONE, '0, -1, NONE, '0);
    run_instr("jmp", 16'hC080, 3'b000, 0, 1,
              mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b11, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0000),
              M_SR1, -1, NONE, '0);
    run_instr("lea", 16'hE7FF, 3'b000, 0, 1,
              mk(0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b11, 3'd0, 3'd0, 3'd3, 1'b0, 16'hFFFF),
              M_DR | M_IMM, -1, NONE, '0);
    run_instr("ld", 16'h2005, 3'b000, 0, 0, NONE, '0, 2,
              mk(1, 0, 1, 1, 1, 0, 2'b01, 2'b00, 2'b11, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0005),
              M_ALU | M_DR | M_IMM);
    run_instr("st", 16'h3205, 3'b000, 0, 0, NONE, '0, 0,
              mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b11, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0005),
              M_ALU | M_SR1 | M_IMM);

    // ST abandoned by reset while waiting in MEM.
    t0 = cyc;
    push("st_rst_fetch", t0, mk(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0), M_ALU);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'h3205;
    step();
    mem_bus.mem_ready = 1'b0;
    step();
    step();
    step();
    check("st_rst_req_held", {61'd0, mem_bus.mem_req, mem_bus.mem_we, mem_bus.addr_sel},
          {61'd0, 3'b111});
    #2;
    rst_n = 1'b0;
    #1;
    check("st_rst_outputs", {25'd0, out_vec}, {25'd0, RST_OUTS});
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("st_rst_refetch", {61'd0, mem_bus.mem_req, mem_bus.addr_sel, mem_bus.mem_we},
          {61'd0, 3'b100});

    run_instr("add_r7", 16'h1E01, 3'b000, 0, 1,
              mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd1, 3'd7, 1'b0, 16'h0000),
              M_ALU | M_SR1 | M_SR2 | M_DR | M_OPB, -1, NONE, '0);

    run_instr("trap", 16'hF025, 3'b000, 0, 0, NONE, '0, -1, NONE, '0);
`ifdef LC3_ILLEGAL_HALT_EN
    mem_bus.mem_ready = 1'b1;
    #1;
    check("halt_illegal", {63'd0, illegal}, 64'd1);
    check("halt_no_req", {63'd0, mem_bus.mem_req}, 64'd0);
    step();
    step();
    step();
    check("halt_illegal_held", {63'd0, illegal}, 64'd1);
    check("halt_no_req_held", {63'd0, mem_bus.mem_req}, 64'd0);
    mem_bus.mem_ready = 1'b0;
`else
    check("nop_illegal_low", {63'd0, illegal}, 64'd0);
    run_instr("after_nop", 16'h1262, 3'b000, 0, 1,
              mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'd1, 3'd0, 3'd1, 1'b1, 16'h0002),
              M_ALU | M_SR1 | M_DR | M_OPB | M_IMM, -1, NONE, '0);
`endif
    step();
    step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
